// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// One operation is in flight at a time: accept in IDLE, drive the ALU in EXEC, return the result in RESP.
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rstn,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_c,
  output logic             rsp0_zero,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_c,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero
);

  localparam logic [OPW-1:0] ALU_NOP = '0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             rr_ptr;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic             zero_q;

  logic grant;
  logic any_valid;
  logic rsp_fire;
  logic in_exec;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = rr_ptr;
    else if (req1_valid)          grant = 1'b1;
  end

  assign any_valid = req0_valid | req1_valid;

  // Gated by rstn so ready reads 0 while reset is held, even if a requester is already valid.
  assign req0_ready = rstn && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rstn && (state == IDLE) && req1_valid &&  grant;

  assign rsp_fire = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
      op_q   <= ALU_NOP;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner <= grant;
            op_q  <= grant ? req1_op : req0_op;
            a_q   <= grant ? req1_a  : req0_a;
            b_q   <= grant ? req1_b  : req0_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          c_q    <= alu_c;
          zero_q <= alu_zero;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rr_ptr <= ~owner;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The shared ALU only sees real operands during EXEC; otherwise it is held quiet.
  assign in_exec = (state == EXEC);
  assign alu_op  = in_exec ? op_q : ALU_NOP;
  assign alu_a   = in_exec ? a_q  : '0;
  assign alu_b   = in_exec ? b_q  : '0;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign rsp0_c     = rsp0_valid ? c_q    : '0;
  assign rsp0_zero  = rsp0_valid ? zero_q : 1'b0;
  assign rsp1_c     = rsp1_valid ? c_q    : '0;
  assign rsp1_zero  = rsp1_valid ? zero_q : 1'b0;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: stimulus pushes expected responses, a monitor pops on each handshake.
// A small behavioural ALU stands in for the external alu instance.
module tb_alu_share_arb;

  localparam int W  = 32;
  localparam int OW = 4;

  localparam logic [OW-1:0] OP_NOP  = 4'd0;
  localparam logic [OW-1:0] OP_ADD  = 4'd1;
  localparam logic [OW-1:0] OP_SUB  = 4'd2;
  localparam logic [OW-1:0] OP_AND  = 4'd3;
  localparam logic [OW-1:0] OP_OR   = 4'd4;
  localparam logic [OW-1:0] OP_SLT  = 4'd5;
  localparam logic [OW-1:0] OP_SLTU = 4'd6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic [OW-1:0] req0_op;
  logic [W-1:0]  req0_a, req0_b, rsp0_c;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [OW-1:0] req1_op;
  logic [W-1:0]  req1_a, req1_b, rsp1_c;
  logic [W-1:0]  alu_a, alu_b, alu_c;
  logic [OW-1:0] alu_op;
  logic          alu_zero;

  typedef struct packed {
    logic         port;
    logic [W-1:0] c;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_share_arb #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_zero(alu_zero)
  );

  // Behavioural stand-in for the external combinational ALU.
  always_comb begin
    alu_c = '0;
    case (alu_op)
      OP_ADD:  alu_c = alu_a + alu_b;
      OP_SUB:  alu_c = alu_a - alu_b;
      OP_AND:  alu_c = alu_a & alu_b;
      OP_OR:   alu_c = alu_a | alu_b;
      OP_SLT:  alu_c = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: alu_c = {{(W-1){1'b0}}, (alu_a < alu_b)};
      default: alu_c = '0;
    endcase
    alu_zero = (alu_c == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  task automatic pop_cmp(input logic port, input logic [W-1:0] c, input logic z);
    exp_t e;
    if (sb.size() == 0) begin
      fail("rsp_unexpected");
    end else begin
      e = sb.pop_front();
      check("rsp_port", 64'(port), 64'(e.port));
      check("rsp_c",    64'(c),    64'(e.c));
      check("rsp_zero", 64'(z),    64'(e.zero));
    end
  endtask

  // Monitor: compares on every response handshake, independent of the stimulus process.
  always @(negedge clk) begin
    if (rstn) begin
      check("rsp_onehot", 64'(rsp0_valid & rsp1_valid), 64'd0);
      if (!rsp0_valid) check("rsp0_idle_out", {31'd0, rsp0_c, rsp0_zero}, 64'd0);
      if (!rsp1_valid) check("rsp1_idle_out", {31'd0, rsp1_c, rsp1_zero}, 64'd0);
      if (rsp0_valid && rsp0_ready) pop_cmp(1'b0, rsp0_c, rsp0_zero);
      if (rsp1_valid && rsp1_ready) pop_cmp(1'b1, rsp1_c, rsp1_zero);
    end
  end

  task automatic drive(input logic p, input logic v, input logic [OW-1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (p) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic issue(input logic p, input logic [OW-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ec, input logic ez,
                       output int acc);
    int   n;
    logic rdy;
    n = 0;
    drive(p, 1'b1, op, a, b);
    @(negedge clk);
    rdy = p ? req1_ready : req0_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = p ? req1_ready : req0_ready;
    end
    acc = cyc;
    if (!rdy) fail(p ? "accept_timeout_1" : "accept_timeout_0");
    else      sb.push_back(exp_t'{port: p, c: ec, zero: ez});
    @(posedge clk);
    #1;
    drive(p, 1'b0, OP_NOP, '0, '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req0_ready"}, 64'(req0_ready), 64'd0);
    check({tag, "_req1_ready"}, 64'(req1_ready), 64'd0);
    check({tag, "_rsp0_valid"}, 64'(rsp0_valid), 64'd0);
    check({tag, "_rsp1_valid"}, 64'(rsp1_valid), 64'd0);
    check({tag, "_rsp0_data"},  {31'd0, rsp0_c, rsp0_zero}, 64'd0);
    check({tag, "_rsp1_data"},  {31'd0, rsp1_c, rsp1_zero}, 64'd0);
    check({tag, "_alu_op"},     64'(alu_op), 64'(OP_NOP));
    check({tag, "_alu_a"},      64'(alu_a), 64'd0);
    check({tag, "_alu_b"},      64'(alu_b), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, a2;
    drive(1'b0, 1'b0, OP_NOP, '0, '0);
    drive(1'b1, 1'b0, OP_NOP, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single op with latency: accept at T, EXEC at T+1, response at T+2
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive(1'b0, 1'b1, OP_ADD, 32'd5, 32'd7);
    @(negedge clk);
    check("t1_req0_ready", 64'(req0_ready), 64'd1);
    check("t1_req1_ready", 64'(req1_ready), 64'd0);
    sb.push_back(exp_t'{port: 1'b0, c: 32'd12, zero: 1'b0});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_NOP, '0, '0);
    @(negedge clk);
    check("t1_exec_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("t1_exec_alu_op", 64'(alu_op), 64'(OP_ADD));
    check("t1_exec_alu_a",  64'(alu_a), 64'd5);
    check("t1_exec_alu_b",  64'(alu_b), 64'd7);
    @(negedge clk);
    check("t1_resp_rsp0_valid", 64'(rsp0_valid), 64'd1);
    check("t1_resp_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("t1_resp_alu_quiet", 64'(alu_op), 64'(OP_NOP));
    drain();

    // Zero flag via requester 1
    issue(1'b1, OP_SUB, 32'h10, 32'h10, 32'd0, 1'b1, a0);
    drain();

    // Contention from reset: grant 0 first, then 1
    rstn = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    fork
      issue(1'b0, OP_OR,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, a0);
      issue(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, a1);
    join
    check("cont_gap", 64'(a1 - a0), 64'd3);
    drain();

    // Backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0;
    issue(1'b0, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, a0);
    drive(1'b1, 1'b1, OP_ADD, 32'd1, 32'd2);
    @(negedge clk);
    check("bp_exec_req1_ready", 64'(req1_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp0_valid", 64'(rsp0_valid), 64'd1);
      check("bp_rsp0_c",     64'(rsp0_c), 64'h0F00_0F00);
      check("bp_rsp0_zero",  64'(rsp0_zero), 64'd0);
      check("bp_req1_ready", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_req1_ready", 64'(req1_ready), 64'd0);
    @(negedge clk);
    check("bp_after_req1_ready", 64'(req1_ready), 64'd1);
    if (req1_ready) sb.push_back(exp_t'{port: 1'b1, c: 32'd3, zero: 1'b0});
    @(posedge clk); #1;
    drive(1'b1, 1'b0, OP_NOP, '0, '0);
    drain();

    // Reset during EXEC drops the transaction
    drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    check("rst_accept", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_NOP, '0, '0);
    #2;
    check("rst_pre_alu_op", 64'(alu_op), 64'(OP_ADD));
    rstn = 1'b0;
    #1;
    check_reset_outputs("midop");
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    end

    // ALU quiescence with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("quiet_alu", {28'd0, alu_op, alu_a | alu_b}, 64'd0);
    end
    @(posedge clk); #1;

    // Three back-to-back requester 0 ops, 3-cycle spacing
    issue(1'b0, OP_ADD,  32'd100, 32'd200, 32'd300,       1'b0, a0);
    issue(1'b0, OP_SUB,  32'd3,   32'd5,   32'hFFFF_FFFE, 1'b0, a1);
    issue(1'b0, OP_SLTU, 32'd1,   32'd2,   32'd1,         1'b0, a2);
    check("b2b_gap1", 64'(a1 - a0), 64'd3);
    check("b2b_gap2", 64'(a2 - a1), 64'd3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
